seven_segment_scan_reader: RTL and testbench

SEVEN_SEGMENT_SCAN_READER -- requirements
Module: seven_segment_scan_reader

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_pattern_decoder.sv | 29 ++
 rtl/seven_segment_scan_reader.sv | 161 ++++++++++++++++
 tb/tb_seven_segment_scan_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state type and helpers for the seven-segment scan reader.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 4;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned REF_W = DIG_N + SEG_W;

  // Active-high {g,f,e,d,c,b,a} patterns for decimal digits
  localparam logic [SEG_W-1:0] PAT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] PAT_1 = 7'h06;
  localparam logic [SEG_W-1:0] PAT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_4 = 7'h66;
  localparam logic [SEG_W-1:0] PAT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] PAT_7 = 7'h07;
  localparam logic [SEG_W-1:0] PAT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9 = 7'h6F;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HELD  = 2'd2
  } dwell_state_e;

  function automatic logic is_one_hot(input logic [DIG_N-1:0] v);
    return (v != '0) && ((v & (v - DIG_N'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [DIG_N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < DIG_N; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational seven-segment pattern to BCD nibble decoder; unknown patterns map to 0xF.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble_c,
  output logic             illegal_c
);

  always_comb begin
    nibble_c = 4'hF;
    case (pattern)
      PAT_0:   nibble_c = 4'h0;
      PAT_1:   nibble_c = 4'h1;
      PAT_2:   nibble_c = 4'h2;
      PAT_3:   nibble_c = 4'h3;
      PAT_4:   nibble_c = 4'h4;
      PAT_5:   nibble_c = 4'h5;
      PAT_6:   nibble_c = 4'h6;
      PAT_7:   nibble_c = 4'h7;
      PAT_8:   nibble_c = 4'h8;
      PAT_9:   nibble_c = 4'h9;
      default: nibble_c = 4'hF;
    endcase
    // 0xF is never produced by a legal pattern
    illegal_c = (nibble_c == 4'hF);
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Snoops a multiplexed 4-digit seven-segment bus and recovers settled digits into
// BCD frames offered on a valid/ready interface.
module seven_segment_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEG_W-1:0]       seg,
  input  logic [DIG_N-1:0]       an,
  output logic [DIG_N*NIB_W-1:0] digits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  dwell_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [REF_W-1:0]                   ref_q, ref_d;
  logic [DIG_N-1:0][NIB_W-1:0]        slot_nib_q, slot_nib_d;
  logic [DIG_N-1:0]                   slot_ill_q, slot_ill_d;
  logic [DIG_N-1:0]                   mask_q, mask_d;
  logic [DIG_N*NIB_W-1:0]             digits_q, digits_d;
  logic                               frame_err_q, frame_err_d;
  logic                               out_valid_q, out_valid_d;
  logic                               overrun_q, overrun_d;

  logic [REF_W-1:0] cur_c;
  logic             changed_c;
  logic             an_one_hot_c;
  logic [IDX_W-1:0] an_idx_c;
  logic [NIB_W-1:0] dec_nibble_c;
  logic             dec_illegal_c;
  logic             sample_c;
  logic             frame_done_c;

  seg7_pattern_decoder u_decoder (
    .pattern   (seg),
    .nibble_c  (dec_nibble_c),
    .illegal_c (dec_illegal_c)
  );

  assign cur_c        = {an, seg};
  assign changed_c    = (cur_c != ref_q);
  assign an_one_hot_c = is_one_hot(an);
  assign an_idx_c     = onehot_idx(an);

  // Dwell tracking, slot capture and frame hand-off
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_d        = ref_q;
    slot_nib_d   = slot_nib_q;
    slot_ill_d   = slot_ill_q;
    mask_d       = mask_q;
    digits_d     = digits_q;
    frame_err_d  = frame_err_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    sample_c     = 1'b0;
    frame_done_c = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (an_one_hot_c) begin
          state_d = ST_DWELL;
          cnt_d   = CNT_W'(1);
          ref_d   = cur_c;
        end
      end
      ST_DWELL: begin
        if (!an_one_hot_c) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (changed_c) begin
          cnt_d = CNT_W'(1);
          ref_d = cur_c;
        end else if (cnt_q < SETTLE) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (changed_c) begin
          if (an_one_hot_c) begin
            state_d = ST_DWELL;
            cnt_d   = CNT_W'(1);
            ref_d   = cur_c;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Sample in the same cycle the dwell count reaches the threshold
    if (state_d == ST_DWELL && cnt_d == SETTLE) begin
      sample_c             = 1'b1;
      state_d              = ST_HELD;
      slot_nib_d[an_idx_c] = dec_nibble_c;
      slot_ill_d[an_idx_c] = dec_illegal_c;
      mask_d[an_idx_c]     = 1'b1;
    end

    frame_done_c = sample_c && (&mask_d);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A completed frame loads only if the output stage is free or draining now
    if (frame_done_c) begin
      mask_d = '0;
      if (!out_valid_q || out_ready) begin
        digits_d    = slot_nib_d;
        frame_err_d = |slot_ill_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      ref_q       <= '0;
      slot_nib_q  <= '0;
      slot_ill_q  <= '0;
      mask_q      <= '0;
      digits_q    <= '0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      slot_nib_q  <= slot_nib_d;
      slot_ill_q  <= slot_ill_d;
      mask_q      <= mask_d;
      digits_q    <= digits_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign digits    = digits_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Directed self-checking bench for the seven-segment scan reader (SETTLE_CYCLES=4).
module tb_seven_segment_scan_reader;

  logic        clk;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        overrun;

  int pass_cnt;
  int total_cnt;
  int xfer_cnt;

  seven_segment_scan_reader #(.SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .an        (an),
    .digits    (digits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) xfer_cnt++;
  end

  // Called at a negedge: apply inputs, then advance n clock cycles to the next negedge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    an    = 4'b0000;
    seg   = 7'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scan_6543();
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h7D, 4);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic_scan();
    do_reset();
    out_ready = 1'b1;
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h7D, 3);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else pass_cnt++;
    drive(4'b1000, 7'h7D, 1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h6543) $display("FAIL basic_digits: got %h want 6543", digits); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL basic_frame_err: got %b want 0", frame_err); else pass_cnt++;
    drive(4'b1000, 7'h7D, 1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_fall: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_short_dwell();
    do_reset();
    out_ready = 1'b1;
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 3);
    drive(4'b1000, 7'h7D, 4);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL short_after_d3: got %b want 0", out_valid); else pass_cnt++;
    drive(4'b0100, 7'h6D, 3);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL short_rescan_early: got %b want 0", out_valid); else pass_cnt++;
    drive(4'b0100, 7'h6D, 1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL short_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h6543) $display("FAIL short_digits: got %h want 6543", digits); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL short_frame_err: got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h49, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h7D, 4);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL illegal_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h65F3) $display("FAIL illegal_digits: got %h want 65F3", digits); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL illegal_frame_err: got %b want 1", frame_err); else pass_cnt++;
  endtask

  task automatic test_not_one_hot();
    do_reset();
    out_ready = 1'b1;
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0011, 7'h4F, 1);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL onehot_valid_c%0d: got %b want 0", i, out_valid); else pass_cnt++;
    end
    // Earlier three slots must survive the non-one-hot interval
    drive(4'b1000, 7'h7D, 4);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL onehot_resume_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h6543) $display("FAIL onehot_resume_digits: got %h want 6543", digits); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    scan_6543();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h6543) $display("FAIL bp_first_digits: got %h want 6543", digits); else pass_cnt++;
    drive(4'b0001, 7'h06, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h7D, 4);
    total_cnt++; if (digits !== 16'h6543) $display("FAIL bp_held_digits: got %h want 6543", digits); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_held_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else pass_cnt++;
    out_ready = 1'b1;
    drive(4'b1000, 7'h7D, 1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL bp_overrun_sticky: got %b want 1", overrun); else pass_cnt++;
    do_reset();
    total_cnt++; if (overrun !== 1'b0) $display("FAIL bp_overrun_cleared: got %b want 0", overrun); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    scan_6543();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", out_valid); else pass_cnt++;
    drive(4'b0001, 7'h06, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h7D, 3);
    total_cnt++; if (digits !== 16'h6543) $display("FAIL b2b_held_digits: got %h want 6543", digits); else pass_cnt++;
    // Accept the old frame in exactly the cycle the new one completes
    out_ready = 1'b1;
    drive(4'b1000, 7'h7D, 1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_kept: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 16'h6541) $display("FAIL b2b_new_digits: got %h want 6541", digits); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_cnt++;
    drive(4'b1000, 7'h7D, 1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_fall: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    out_ready = 1'b1;
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    reset = 1'b1;
    drive(4'b0000, 7'h00, 1);
    total_cnt++; if (digits !== 16'h0000) $display("FAIL midrst_digits: got %h want 0000", digits); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL midrst_frame_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL midrst_overrun: got %b want 0", overrun); else pass_cnt++;
    reset = 1'b0;
    base  = xfer_cnt;
    // Digit 3 first so any surviving partial mask would complete a frame early
    drive(4'b1000, 7'h7D, 4);
    drive(4'b0001, 7'h4F, 4);
    drive(4'b0010, 7'h66, 4);
    drive(4'b0100, 7'h6D, 4);
    total_cnt++; if (digits !== 16'h6543) $display("FAIL midrst_digits_after: got %h want 6543", digits); else pass_cnt++;
    drive(4'b0100, 7'h6D, 2);
    total_cnt++; if (xfer_cnt - base !== 1) $display("FAIL midrst_frame_count: got %0d want 1", xfer_cnt - base); else pass_cnt++;
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    an        = 4'b0000;
    seg       = 7'h00;
    out_ready = 1'b1;
    pass_cnt  = 0;
    total_cnt = 0;
    xfer_cnt  = 0;
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_illegal();
    test_not_one_hot();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
